// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// State encoding, frame field widths and the default sync marker.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         BYTE_W        = 8;
    localparam int         WORD_W        = 32;
    localparam int         LANE_W        = 2;

    // States in which a byte belongs to a frame being received
    function automatic logic in_frame_st(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/lmem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid pulses combinationally with the 4th byte of each word.
module lmem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] shreg;

    // Byte lane counter and shift register; newest byte enters at the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane  <= '0;
            shreg <= '0;
        end else if (clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + LANE_W'(1);
            shreg <= {byte_in, shreg[WORD_W-1:BYTE_W]};
        end
    end

    assign word_valid = byte_valid && !clear && (lane == '1);
    assign word       = {byte_in, shreg[WORD_W-1:BYTE_W]};

endmodule

// File: rtl/imem_loader.sv
// Host byte-stream loader for the instruction memory.
// Holds the core in reset until a checksummed frame has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH_WORDS    = 64,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam int CNT_W = $clog2(DEPTH_WORDS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WORD_W-1:0] DEPTH_LIM = WORD_W'(DEPTH_WORDS);

    state_t              state;
    state_t              state_n;
    logic                accepted;
    logic                in_frame;
    logic                start;
    logic                feed;
    logic                timeout;
    logic                last_word;
    logic                word_valid;
    logic [WORD_W-1:0]   word;
    logic [CNT_W-1:0]    word_cnt;
    logic [CNT_W-1:0]    len_words;
    logic [BYTE_W-1:0]   sum;
    logic [TMR_W-1:0]    timer;

    assign rx_ready  = !imem_we;
    assign accepted  = rx_valid && rx_ready;
    assign in_frame  = in_frame_st(state);
    assign start     = accepted && !in_frame && (rx_data == SYNC_BYTE);
    assign feed      = accepted && ((state == ST_LEN) || (state == ST_DATA));
    assign timeout   = in_frame && !accepted && (timer == TMR_LAST);
    assign last_word = (word_cnt == len_words - CNT_W'(1));

    // Length word and data words share one packer, cleared at each sync
    lmem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_valid (feed),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Frame sequencing; an accepted byte always pre-empts a timeout
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_n = ST_LEN;
            end
            ST_LEN: begin
                if (word_valid) begin
                    if (word == '0)            state_n = ST_CHK;
                    else if (word > DEPTH_LIM) state_n = ST_ERR;
                    else                       state_n = ST_DATA;
                end else if (timeout) begin
                    state_n = ST_ERR;
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) state_n = ST_CHK;
                else if (timeout)            state_n = ST_ERR;
            end
            ST_CHK: begin
                if (accepted)     state_n = (rx_data == sum) ? ST_DONE : ST_ERR;
                else if (timeout) state_n = ST_ERR;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Word counter, frame length and running data checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt  <= '0;
            len_words <= '0;
            sum       <= '0;
        end else if (start) begin
            word_cnt  <= '0;
            len_words <= '0;
            sum       <= '0;
        end else begin
            if ((state == ST_LEN) && word_valid)
                len_words <= word[CNT_W-1:0];
            if ((state == ST_DATA) && accepted)
                sum <= sum + rx_data;
            if ((state == ST_DATA) && word_valid)
                word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Inter-byte idle timer, only running inside a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      timer <= '0;
        else if (!in_frame || accepted) timer <= '0;
        else                            timer <= timer + TMR_W'(1);
    end

    // Memory write port; address holds between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= (state == ST_DATA) && word_valid;
            if ((state == ST_DATA) && word_valid) begin
                imem_addr  <= WORD_W'(word_cnt) << 2;
                imem_wdata <= word;
            end
        end
    end

    assign cpu_reset  = (state != ST_DONE);
    assign load_done  = (state == ST_DONE);
    assign load_error = (state == ST_ERR);

endmodule
